// File: rtl/req_pending_latch.sv
// Request capture stage ahead of the priority encoder: synchronises raw request
// lines, turns their rising edges into sticky pending bits, and clears one bit per acknowledge.
module req_pending_latch #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDXW        = 3,
  parameter int CNTW        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_in,
  input  logic            en_in,
  input  logic            ack,
  input  logic [IDXW-1:0] ack_idx,
  input  logic            ovf_clr,
  output logic [N-1:0]    pend_x,
  output logic            pend_en,
  output logic            pend_any,
  output logic [CNTW-1:0] pend_cnt,
  output logic [N-1:0]    ovf,
  output logic            ack_err
);

  localparam logic [N-1:0] ONE = N'(1);

  function automatic logic [CNTW-1:0] popcnt(input logic [N-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNTW'(v[i]);
    return c;
  endfunction

  logic [N-1:0]    r_sync [SYNC_STAGES];
  logic [N-1:0]    r_hist;
  logic [N-1:0]    r_pend_x;
  logic [N-1:0]    r_ovf;
  logic [CNTW-1:0] r_pend_cnt;
  logic            r_pend_en;
  logic            r_ack_err;

  logic [N-1:0]    w_rise;
  logic [N-1:0]    w_onehot;
  logic            w_ack_ok;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_ovf_set;
  logic [N-1:0]    w_pend_next;

  // Synchroniser chain and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // An out-of-range index shifts the one-hot to zero, so it can never hit a pending bit.
  always_comb begin
    w_rise      = r_sync[SYNC_STAGES-1] & ~r_hist & {N{en_in}};
    w_onehot    = ONE << ack_idx;
    w_ack_ok    = ack & (|(w_onehot & r_pend_x));
    w_clr       = w_ack_ok ? w_onehot : '0;
    w_ovf_set   = w_rise & r_pend_x & ~w_clr;
    w_pend_next = (r_pend_x & ~w_clr) | w_rise;
  end

  // Pending state and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_x   <= '0;
      r_pend_cnt <= '0;
      r_ovf      <= '0;
      r_pend_en  <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      r_pend_x   <= w_pend_next;
      r_pend_cnt <= popcnt(w_pend_next);
      r_ovf      <= ovf_clr ? w_ovf_set : (r_ovf | w_ovf_set);
      r_pend_en  <= en_in;
      r_ack_err  <= ack & ~w_ack_ok;
    end
  end

  assign pend_x   = r_pend_x;
  assign pend_en  = r_pend_en;
  assign pend_any = |r_pend_x;
  assign pend_cnt = r_pend_cnt;
  assign ovf      = r_ovf;
  assign ack_err  = r_ack_err;

endmodule
